// File: rtl/rv32_alu_pkg.sv
// Shared ALU opcodes, FSM state encoding and the single-cycle ALU function for the RV32I execute stage.
package rv32_alu_pkg;

  localparam int XLEN    = 32;
  localparam int SHAMT_W = 5;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_WB    = 2'd2
  } state_e;

  function automatic logic is_shift_op(input logic [3:0] op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

  // Shift codes return operand A: only reached when the shift amount is zero.
  function automatic logic [XLEN-1:0] alu_compute(input logic [3:0] op,
                                                  input logic [XLEN-1:0] a,
                                                  input logic [XLEN-1:0] b);
    logic [XLEN-1:0] r;
    r = '0;
    case (op)
      ALU_ADD:   r = a + b;
      ALU_SUB:   r = a - b;
      ALU_SLT:   r = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SLTU:  r = {{(XLEN-1){1'b0}}, a < b};
      ALU_XOR:   r = a ^ b;
      ALU_OR:    r = a | b;
      ALU_AND:   r = a & b;
      ALU_PASSB: r = b;
      ALU_SLL, ALU_SRL, ALU_SRA: r = a;
      default:   r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rv32_execute_if.sv
// Issue bus from decode into the execute stage (valid/ready plus operands and control).
interface rv32_execute_if;
  import rv32_alu_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [3:0]      alu_op;
  logic            use_imm;
  logic [4:0]      rd_address_i;
  logic [XLEN-1:0] rs1_value;
  logic [XLEN-1:0] rs2_value;
  logic [XLEN-1:0] imm;

  modport master (
    output in_valid, alu_op, use_imm, rd_address_i, rs1_value, rs2_value, imm,
    input  in_ready
  );

  modport slave (
    input  in_valid, alu_op, use_imm, rd_address_i, rs1_value, rs2_value, imm,
    output in_ready
  );
endinterface

// File: rtl/rv32_serial_shifter.sv
// Bit-serial shifter: shifts the held operand one position per step until the count runs out.
// Latency: n steps for a shift by n; done is high while the final step is pending.
// Backpressure: none; the owner only steps it while its FSM sits in the shift state.
module rv32_serial_shifter
  import rv32_alu_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load,
  input  logic               step,
  input  logic [XLEN-1:0]    load_value,
  input  logic [SHAMT_W-1:0] load_amount,
  input  logic               dir_right,
  input  logic               arith,
  output logic [XLEN-1:0]    value,
  output logic               done
);

  logic [XLEN-1:0]    value_q;
  logic [SHAMT_W-1:0] count_q;
  logic               right_q;
  logic               arith_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      value_q <= '0;
      count_q <= '0;
      right_q <= 1'b0;
      arith_q <= 1'b0;
    end else if (load) begin
      value_q <= load_value;
      count_q <= load_amount;
      right_q <= dir_right;
      arith_q <= arith;
    end else if (step && (count_q != '0)) begin
      value_q <= right_q ? {arith_q & value_q[XLEN-1], value_q[XLEN-1:1]}
                         : {value_q[XLEN-2:0], 1'b0};
      count_q <= count_q - 1'b1;
    end
  end

  assign value = value_q;
  assign done  = (count_q == SHAMT_W'(1));

endmodule

// File: rtl/rv32_execute.sv
// RV32I execute stage: single-cycle ALU plus bit-serial shifts, one-cycle register file write pulse.
// Latency: 1 cycle for non-shift ops and zero-amount shifts, n+1 cycles for a shift by n.
// Backpressure: in_ready drops for the whole shift, stalling decode; back-to-back issue otherwise.
module rv32_execute
  import rv32_alu_pkg::*;
(
  input  logic            clk,
  input  logic            reset_n,
  rv32_execute_if.slave   in_if,
  output logic [4:0]      rd_address,
  output logic [XLEN-1:0] rd_value,
  output logic            busy,
  output logic            illegal_op
);

  state_e             state, state_d;
  logic [XLEN-1:0]    op_b, alu_res, result_q, sh_value;
  logic [SHAMT_W-1:0] shamt;
  logic               xfer, op_shift, op_illegal, sh_load, sh_done;
  logic [4:0]         rd_q;
  logic               illegal_q, sel_shift_q;

  assign op_b       = in_if.use_imm ? in_if.imm : in_if.rs2_value;
  assign shamt      = op_b[SHAMT_W-1:0];
  assign op_illegal = (in_if.alu_op > ALU_PASSB);
  assign op_shift   = is_shift_op(in_if.alu_op) && (shamt != '0);
  assign alu_res    = alu_compute(in_if.alu_op, in_if.rs1_value, op_b);

  assign in_if.in_ready = reset_n & ((state == S_IDLE) | (state == S_WB));
  assign xfer           = in_if.in_valid & in_if.in_ready;
  assign sh_load        = xfer & op_shift;

  rv32_serial_shifter u_shifter (
    .clk         (clk),
    .reset_n     (reset_n),
    .load        (sh_load),
    .step        (state == S_SHIFT),
    .load_value  (in_if.rs1_value),
    .load_amount (shamt),
    .dir_right   (in_if.alu_op != ALU_SLL),
    .arith       (in_if.alu_op == ALU_SRA),
    .value       (sh_value),
    .done        (sh_done)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE, S_WB: begin
        if (xfer) state_d = op_shift ? S_SHIFT : S_WB;
        else      state_d = S_IDLE;
      end
      S_SHIFT:  if (sh_done) state_d = S_WB;
      default:  state_d = S_IDLE;
    endcase
  end

  // Illegal ops keep the previous result visible and suppress the write via rd_q = 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_q        <= '0;
      illegal_q   <= 1'b0;
      sel_shift_q <= 1'b0;
      result_q    <= '0;
    end else if (xfer) begin
      rd_q      <= op_illegal ? 5'd0 : in_if.rd_address_i;
      illegal_q <= op_illegal;
      if (!op_illegal) begin
        sel_shift_q <= op_shift;
        if (!op_shift) result_q <= alu_res;
      end
    end
  end

  assign rd_address = (state == S_WB) ? rd_q : 5'd0;
  assign rd_value   = sel_shift_q ? sh_value : result_q;
  assign busy       = (state == S_SHIFT);
  assign illegal_op = (state == S_WB) & illegal_q;

endmodule

// File: tb/tb_rv32_execute.sv
// Table-driven and scoreboard-checked bench for the RV32I execute stage.
module tb_rv32_execute;
  import rv32_alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [4:0]  rd_address;
  logic [31:0] rd_value;
  logic        busy, illegal_op;
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;

  rv32_execute_if bus ();

  rv32_execute dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_if      (bus),
    .rd_address (rd_address),
    .rd_value   (rd_value),
    .busy       (busy),
    .illegal_op (illegal_op)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0]  op;
    logic        ui;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] im;
    logic [4:0]  rd;
    logic [31:0] ev;
    int          lat;
  } vec_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] val;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  vec_t vt[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Every nonzero write must match the oldest outstanding expectation, including its latency.
  always @(negedge clk) begin
    if (rd_address != 5'd0) begin
      if (sb.size() == 0) begin
        chk("unexpected_write", 32'(rd_address), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("wb_rd", 32'(rd_address), 32'(e.rd));
        chk("wb_value", rd_value, e.val);
        chk("wb_latency", 32'(cyc - e.acc), 32'(e.lat));
      end
    end
  end

  task automatic issue(input logic [3:0] op, input logic ui, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] im, input logic [4:0] rd,
                       input bit push, input logic [31:0] ev, input int lat, input bit need_rdy);
    int n;
    @(negedge clk);
    bus.alu_op = op; bus.use_imm = ui; bus.rs1_value = a; bus.rs2_value = b;
    bus.imm = im; bus.rd_address_i = rd; bus.in_valid = 1'b1;
    if (need_rdy) chk("in_ready_b2b", 32'(bus.in_ready), 32'd1);
    n = 0;
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) chk("issue_timeout", 32'(bus.in_ready), 32'd1);
    if (push) sb.push_back('{rd, ev, lat, cyc});
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", 32'(sb.size()), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = '{ALU_ADD,   1'b1, 32'h7FFFFFFF, 32'h0,        32'h1,        5'd5,  32'h80000000, 1};
    vt[1]  = '{ALU_SUB,   1'b0, 32'h00000005, 32'h7,        32'h0,        5'd1,  32'hFFFFFFFE, 1};
    vt[2]  = '{ALU_SLT,   1'b0, 32'hFFFFFFFF, 32'h1,        32'h0,        5'd4,  32'h00000001, 1};
    vt[3]  = '{ALU_SLTU,  1'b0, 32'hFFFFFFFF, 32'h1,        32'h0,        5'd6,  32'h00000000, 1};
    vt[4]  = '{ALU_XOR,   1'b0, 32'hA5A5A5A5, 32'hFFFF0000, 32'h0,        5'd7,  32'h5A5AA5A5, 1};
    vt[5]  = '{ALU_OR,    1'b1, 32'hF0F00000, 32'h0,        32'h0000F0F0, 5'd8,  32'hF0F0F0F0, 1};
    vt[6]  = '{ALU_AND,   1'b0, 32'h12345678, 32'h0F0F0F0F, 32'h0,        5'd10, 32'h02040608, 1};
    vt[7]  = '{ALU_PASSB, 1'b1, 32'h11111111, 32'h0,        32'hABCDE000, 5'd11, 32'hABCDE000, 1};
    vt[8]  = '{ALU_SLL,   1'b0, 32'h00000001, 32'd31,       32'h0,        5'd12, 32'h80000000, 32};
    vt[9]  = '{ALU_SRL,   1'b0, 32'h80000000, 32'h21,       32'h0,        5'd13, 32'h40000000, 2};
    vt[10] = '{ALU_SRA,   1'b1, 32'h80000001, 32'h0,        32'd3,        5'd14, 32'hF0000000, 4};
    vt[11] = '{ALU_SLL,   1'b0, 32'hDEADBEEF, 32'h0,        32'h0,        5'd15, 32'hDEADBEEF, 1};
    vt[12] = '{ALU_SUB,   1'b0, 32'h00000000, 32'h1,        32'h0,        5'd16, 32'hFFFFFFFF, 1};
    vt[13] = '{ALU_SLT,   1'b0, 32'h00000001, 32'hFFFFFFFF, 32'h0,        5'd17, 32'h00000000, 1};

    // Reset with a request held: nothing may be accepted or written.
    bus.in_valid = 1'b1; bus.alu_op = ALU_ADD; bus.use_imm = 1'b1; bus.rd_address_i = 5'd5;
    bus.rs1_value = 32'h1; bus.rs2_value = 32'h0; bus.imm = 32'h1;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_rd_address", 32'(rd_address), 32'd0);
    chk("rst_rd_value", rd_value, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_illegal", 32'(illegal_op), 32'd0);
    bus.in_valid = 1'b0;
    reset_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    repeat (3) @(negedge clk);
    chk("post_rst_no_write", 32'(rd_address), 32'd0);

    for (int i = 0; i < 14; i++) begin
      issue(vt[i].op, vt[i].ui, vt[i].a, vt[i].b, vt[i].im, vt[i].rd, 1'b1, vt[i].ev, vt[i].lat, 1'b0);
      idle();
      drain();
    end

    // ADD pulse lasts exactly one cycle.
    issue(ALU_ADD, 1'b1, 32'h7FFFFFFF, 32'h0, 32'h1, 5'd5, 1'b1, 32'h80000000, 1, 1'b0);
    idle();
    @(negedge clk);
    chk("add_pulse_end", 32'(rd_address), 32'd0);
    chk("add_value_held", rd_value, 32'h80000000);
    drain();

    // SRA by 4: four busy cycles with in_ready low, write in the fifth.
    issue(ALU_SRA, 1'b0, 32'h80000000, 32'd4, 32'h0, 5'd3, 1'b1, 32'hF8000000, 5, 1'b0);
    idle();
    for (int k = 0; k < 4; k++) begin
      chk("sra_busy", 32'(busy), 32'd1);
      chk("sra_in_ready", 32'(bus.in_ready), 32'd0);
      @(negedge clk);
    end
    chk("sra_busy_done", 32'(busy), 32'd0);
    chk("sra_wb_rd", 32'(rd_address), 32'd3);
    drain();

    // Back-to-back SUB then SLTU.
    issue(ALU_SUB, 1'b0, 32'd5, 32'd7, 32'h0, 5'd1, 1'b1, 32'hFFFFFFFE, 1, 1'b0);
    issue(ALU_SLTU, 1'b0, 32'd1, 32'hFFFFFFFF, 32'h0, 5'd2, 1'b1, 32'h00000001, 1, 1'b1);
    idle();
    chk("b2b_second_wb", 32'(rd_address), 32'd2);
    drain();

    // Illegal opcode 13.
    issue(4'd13, 1'b0, 32'h1, 32'h2, 32'h0, 5'd9, 1'b0, 32'h0, 0, 1'b0);
    idle();
    chk("illegal_pulse", 32'(illegal_op), 32'd1);
    chk("illegal_no_write", 32'(rd_address), 32'd0);
    @(negedge clk);
    chk("illegal_pulse_end", 32'(illegal_op), 32'd0);

    // Reset in the middle of SLL by 20: the op is dropped.
    issue(ALU_SLL, 1'b0, 32'h1, 32'd20, 32'h0, 5'd20, 1'b0, 32'h0, 0, 1'b0);
    idle();
    repeat (5) @(negedge clk);
    chk("sll_busy_before_rst", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (25) @(negedge clk);
    chk("midrst_no_write", 32'(rd_address), 32'd0);
    issue(ALU_ADD, 1'b0, 32'd2, 32'd3, 32'h0, 5'd21, 1'b1, 32'd5, 1, 1'b0);
    idle();
    drain();

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
